posit_mac_feeder: RTL and testbench
===================================

// Module: posit_mac_feeder
// PURPOSE
// Operand sequencer directly upstream of the posit MAC datapath (decode/mult/accumulate/encode).
// Loads K posit weights once, then streams NWIN windows of K activations as (win,din,vld) beats.
// Captures each window's posit result (acc_o/vld_o pulse) into a one-entry ready/valid output buffer.
// Guarantees the MAC never receives beats of window n+1 before window n's result is held.
// PARAMETERS
// WIDTH   8   posit word width (weights, activations, result)
// K       9   beats per window; must equal the MAC's K
// NWIN_W  16  width of the window-count configuration
// PORTS
// clk_i       in   1       clock, rising edge
// rstn        in   1       synchronous reset, active low
// start_i     in   1       pulse: begin job (sampled in IDLE only)
// cfg_nwin_i  in   NWIN_W  windows in job, sampled with start_i
// w_vld_i     in   1       weight beat valid (always accepted in LOAD_W)
// w_data_i    in   WIDTH   weight posit, index 0..K-1 in arrival order
// d_vld_i     in   1       activation valid
// d_rdy_o     out  1       activation ready
// d_data_i    in   WIDTH   activation posit
// mac_vld_o   out  1       to MAC vld_i
// mac_win_o   out  WIDTH   to MAC win
// mac_din_o   out  WIDTH   to MAC din
// mac_vld_i   in   1       from MAC vld_o (1-cycle pulse)
// mac_acc_i   in   WIDTH   from MAC acc_o
// res_vld_o   out  1       result valid
// res_rdy_i   in   1       result ready
// res_data_o  out  WIDTH   result posit
// busy_o      out  1       state != IDLE
// done_o      out  1       1-cycle pulse at job end
// err_o       out  1       sticky: mac_vld_i seen outside WAIT_RES
// BEHAVIOUR
// - Reset (rstn=0 at clk edge): state IDLE; all outputs 0; weight regs, counters, result buffer cleared.
//   Reset mid-job aborts it: no done_o, buffered result dropped.
// - FSM: IDLE -start_i&nwin!=0-> LOAD_W; IDLE -start_i&nwin==0-> IDLE with done_o next cycle.
//   LOAD_W: w_vld_i writes w[widx], widx++; after K-th beat -> STREAM (widx wraps to 0).
//   STREAM: d_rdy_o = (bidx<K) & ~res_vld_o; accept on d_vld_i&d_rdy_o, bidx++;
//     after K-th accept -> WAIT_RES, bidx=0.
//   WAIT_RES: d_rdy_o=0; on mac_vld_i load buffer (res_data_o=mac_acc_i, res_vld_o=1), win_cnt++;
//     if win_cnt+1==nwin -> DRAIN else -> STREAM.
//   DRAIN: when buffer empties (res_vld_o&res_rdy_i) -> IDLE, done_o pulses that same cycle+1.
// - Beat timing: accept at edge t -> mac_vld_o=1 in cycle t+1 with mac_win_o=w[bidx_at_accept],
//   mac_din_o=d_data_i; mac_vld_o=0 otherwise (win/din hold last values). Back-to-back beats at full rate.
// - Result buffer: res_vld_o holds with stable res_data_o until res_rdy_i; cleared on handshake.
//   STREAM of next window waits for buffer empty, so WAIT_RES always has a free entry.
//   Handshake and new load in same cycle cannot occur (invariant; assert in sim).
// - mac_vld_i in any state other than WAIT_RES: ignored, err_o<=1 (cleared only by reset).
// - start_i while busy_o: ignored. w_vld_i outside LOAD_W: ignored.
// - d_vld_i may drop mid-window: beats resume without gap penalty; bidx preserved.
// - Weights persist across all windows of a job; reloaded every job.
// - Counter widths: widx,bidx $clog2(K+1); win_cnt NWIN_W; nwin=2^NWIN_W-1 supported.
// STRUCTURE
// - Shared package posit_mac_pkg: FSM state encodings (IDLE,LOAD_W,STREAM,WAIT_RES,DRAIN),
//   WK=$clog2(K+1), default WIDTH/K shared with MAC top.
// - One sub-module: posit_wbuf (K x WIDTH register file, sync write port, comb read by index).
// - Top holds FSM, counters, beat register stage, result buffer.
// TESTING
// 1 K=9, nwin=1, weights 0x40 x9, acts 0x40 x9 back-to-back -> 9 mac_vld_o beats in 9 consecutive
//   cycles, win=din=0x40; model returns 0x5A -> res_data_o=0x5A, done_o one cycle after res handshake.
// 2 nwin=3, res_rdy_i held 0 -> after window 1 result, d_rdy_o stays 0; releasing res_rdy_i resumes
//   window 2; total 27 beats, 3 results in order, one done_o.
// 3 d_vld_i toggled 1,0,1,0... -> beats only on accepts, mac_win_o index matches w[0..8] sequence.
// 4 start_i with cfg_nwin_i=0 -> no d_rdy_o/mac_vld_o, done_o=1 next cycle, busy_o never 1.
// 5 mac_vld_i pulse during STREAM -> err_o=1 sticky, buffer unchanged; later result still captured.
// 6 rstn=0 mid-window (beat 5) -> next cycle all outputs 0, IDLE; new job completes normally.

Source files
------------

// File: rtl/posit_mac_pkg.sv
// ----------------------------------------------------------------------------
// posit_mac_pkg
// Definitions shared by the posit MAC feeder and the MAC datapath top:
//   - default posit word width, window length and window-count width
//   - WK: index/counter width able to hold the values 0..K
//   - state_t: feeder FSM state encoding
// ----------------------------------------------------------------------------
package posit_mac_pkg;

   localparam int WIDTH_DEF  = 8;
   localparam int K_DEF      = 9;
   localparam int NWIN_W_DEF = 16;
   localparam int WK         = $clog2(K_DEF + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD_W   = 3'd1,
      STREAM   = 3'd2,
      WAIT_RES = 3'd3,
      DRAIN    = 3'd4
   } state_t;

endpackage

// File: rtl/posit_mac_feeder_if.sv
// ----------------------------------------------------------------------------
// posit_mac_feeder_if
// Bundles every feeder signal except clock and reset.
//   control : start_i, cfg_nwin_i, busy_o, done_o, err_o
//   weights : w_vld_i, w_data_i
//   acts    : d_vld_i, d_rdy_o, d_data_i
//   to MAC  : mac_vld_o, mac_win_o, mac_din_o
//   from MAC: mac_vld_i, mac_acc_i
//   result  : res_vld_o, res_rdy_i, res_data_o
// Modport slave is the feeder side; master is the environment side.
// ----------------------------------------------------------------------------
interface posit_mac_feeder_if
   import posit_mac_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int NWIN_W = NWIN_W_DEF
);

   logic              start_i;
   logic [NWIN_W-1:0] cfg_nwin_i;
   logic              w_vld_i;
   logic [WIDTH-1:0]  w_data_i;
   logic              d_vld_i;
   logic              d_rdy_o;
   logic [WIDTH-1:0]  d_data_i;
   logic              mac_vld_o;
   logic [WIDTH-1:0]  mac_win_o;
   logic [WIDTH-1:0]  mac_din_o;
   logic              mac_vld_i;
   logic [WIDTH-1:0]  mac_acc_i;
   logic              res_vld_o;
   logic              res_rdy_i;
   logic [WIDTH-1:0]  res_data_o;
   logic              busy_o;
   logic              done_o;
   logic              err_o;

   modport slave (
      input  start_i, cfg_nwin_i, w_vld_i, w_data_i, d_vld_i, d_data_i,
             mac_vld_i, mac_acc_i, res_rdy_i,
      output d_rdy_o, mac_vld_o, mac_win_o, mac_din_o, res_vld_o, res_data_o,
             busy_o, done_o, err_o
   );

   modport master (
      output start_i, cfg_nwin_i, w_vld_i, w_data_i, d_vld_i, d_data_i,
             mac_vld_i, mac_acc_i, res_rdy_i,
      input  d_rdy_o, mac_vld_o, mac_win_o, mac_din_o, res_vld_o, res_data_o,
             busy_o, done_o, err_o
   );

endinterface

// File: rtl/posit_wbuf.sv
// ----------------------------------------------------------------------------
// posit_wbuf
// K x WIDTH weight register file: one synchronous write port, one
// combinational read port addressed by beat index.
//   clk_i   in  clock, rising edge
//   rstn    in  synchronous reset, active low (clears all entries)
//   i_we    in  write enable
//   i_widx  in  write index 0..K-1
//   i_wdata in  write data
//   i_ridx  in  read index 0..K-1
//   o_rdata out read data (0 for an index outside 0..K-1)
// ----------------------------------------------------------------------------
module posit_wbuf
   import posit_mac_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int K     = K_DEF,
   parameter int IDX_W = $clog2(K + 1)
) (
   input  logic             clk_i,
   input  logic             rstn,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_widx,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [IDX_W-1:0] i_ridx,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [K];

   // NOTE: clocked state uses non-blocking (<=) so every register samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk_i) begin
      if (!rstn) begin
         // NOTE: this small register file is reset (an aborted job must not
         // leave stale weights); large RAMs normally are not.
         for (int i = 0; i < K; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         for (int i = 0; i < K; i++)
            if (i_widx == IDX_W'(i)) r_mem[i] <= i_wdata;
      end
   end

   always_comb begin
      // NOTE: default assigned first so no path leaves o_rdata unassigned,
      // which would infer a latch.
      o_rdata = '0;
      for (int i = 0; i < K; i++)
         if (i_ridx == IDX_W'(i)) o_rdata = r_mem[i];
   end

endmodule

// File: rtl/posit_mac_feeder.sv
// ----------------------------------------------------------------------------
// posit_mac_feeder
// Operand sequencer in front of the posit MAC. Loads K weights once per job,
// then streams NWIN windows of K activations as (win, din, vld) beats and
// captures each window result into a one-entry ready/valid buffer. A new
// window is not started until the previous result has left the buffer, so the
// MAC never sees window n+1 before window n's result is held.
//   clk_i, rstn : clock (rising edge), synchronous active-low reset
//   bus (slave) : start_i/cfg_nwin_i job control, w_* weight load,
//                 d_* activation stream, mac_* MAC beat/result interface,
//                 res_* result buffer, busy_o/done_o/err_o status
// ----------------------------------------------------------------------------
module posit_mac_feeder
   import posit_mac_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int K      = K_DEF,
   parameter int NWIN_W = NWIN_W_DEF
) (
   input  logic              clk_i,
   input  logic              rstn,
   posit_mac_feeder_if.slave bus
);

   localparam int               IDX_W    = $clog2(K + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K - 1);
   localparam logic [IDX_W-1:0] IDX_K    = IDX_W'(K);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDX_W-1:0]  r_widx;
   logic [IDX_W-1:0]  r_bidx;
   logic [NWIN_W-1:0] r_nwin;
   logic [NWIN_W-1:0] r_win_cnt;
   logic [NWIN_W-1:0] w_win_nxt;
   logic              r_mac_vld;
   logic [WIDTH-1:0]  r_mac_win;
   logic [WIDTH-1:0]  r_mac_din;
   logic              r_res_vld;
   logic [WIDTH-1:0]  r_res_data;
   logic              r_done;
   logic              r_err;

   logic              w_start_job;
   logic              w_w_we;
   logic              w_d_rdy;
   logic              w_accept;
   logic              w_res_load;
   logic              w_res_take;
   logic              w_done_set;
   logic [WIDTH-1:0]  w_wgt;

   posit_wbuf #(
      .WIDTH (WIDTH),
      .K     (K),
      .IDX_W (IDX_W)
   ) u_wbuf (
      .clk_i   (clk_i),
      .rstn    (rstn),
      .i_we    (w_w_we),
      .i_widx  (r_widx),
      .i_wdata (bus.w_data_i),
      .i_ridx  (r_bidx),
      .o_rdata (w_wgt)
   );

   assign w_win_nxt  = r_win_cnt + NWIN_W'(1);
   // The buffer drains in any state; a pending result only blocks STREAM.
   assign w_res_take = r_res_vld & bus.res_rdy_i;

   always_ff @(posedge clk_i) begin
      if (!rstn) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start_job = 1'b0;
      w_w_we      = 1'b0;
      w_d_rdy     = 1'b0;
      w_accept    = 1'b0;
      w_res_load  = 1'b0;
      w_done_set  = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start_i) begin
               if (bus.cfg_nwin_i != '0) begin
                  w_start_job = 1'b1;
                  w_state_nxt = LOAD_W;
               end else begin
                  // Empty job: finish immediately without leaving IDLE.
                  w_done_set = 1'b1;
               end
            end
         end
         LOAD_W: begin
            if (bus.w_vld_i) begin
               w_w_we = 1'b1;
               if (r_widx == IDX_LAST) w_state_nxt = STREAM;
            end
         end
         STREAM: begin
            w_d_rdy  = (r_bidx < IDX_K) & ~r_res_vld;
            w_accept = bus.d_vld_i & w_d_rdy;
            if (w_accept && r_bidx == IDX_LAST) w_state_nxt = WAIT_RES;
         end
         WAIT_RES: begin
            if (bus.mac_vld_i) begin
               w_res_load  = 1'b1;
               w_state_nxt = (w_win_nxt == r_nwin) ? DRAIN : STREAM;
            end
         end
         DRAIN: begin
            if (w_res_take) begin
               w_done_set  = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn) begin
         r_widx     <= '0;
         r_bidx     <= '0;
         r_nwin     <= '0;
         r_win_cnt  <= '0;
         r_mac_vld  <= 1'b0;
         r_mac_win  <= '0;
         r_mac_din  <= '0;
         r_res_vld  <= 1'b0;
         r_res_data <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         if (w_start_job) begin
            r_nwin    <= bus.cfg_nwin_i;
            r_win_cnt <= '0;
            r_widx    <= '0;
            r_bidx    <= '0;
         end

         if (w_w_we) r_widx <= (r_widx == IDX_LAST) ? '0 : r_widx + IDX_W'(1);

         // Beat stage: a pulse per accept; win/din hold between beats.
         r_mac_vld <= w_accept;
         if (w_accept) begin
            r_mac_win <= w_wgt;
            r_mac_din <= bus.d_data_i;
            r_bidx    <= (r_bidx == IDX_LAST) ? '0 : r_bidx + IDX_W'(1);
         end

         // STREAM waits for an empty buffer, so a load never meets a take.
         assert (!(w_res_load && w_res_take));
         if (w_res_load) begin
            r_res_vld  <= 1'b1;
            r_res_data <= bus.mac_acc_i;
            r_win_cnt  <= w_win_nxt;
         end else if (w_res_take) begin
            r_res_vld <= 1'b0;
         end

         r_done <= w_done_set;

         if (bus.mac_vld_i && r_state != WAIT_RES) r_err <= 1'b1;
      end
   end

   assign bus.d_rdy_o    = w_d_rdy;
   assign bus.mac_vld_o  = r_mac_vld;
   assign bus.mac_win_o  = r_mac_win;
   assign bus.mac_din_o  = r_mac_din;
   assign bus.res_vld_o  = r_res_vld;
   assign bus.res_data_o = r_res_data;
   assign bus.busy_o     = (r_state != IDLE);
   assign bus.done_o     = r_done;
   assign bus.err_o      = r_err;

endmodule

// File: tb/tb_posit_mac_feeder.sv
// ----------------------------------------------------------------------------
// tb_posit_mac_feeder
// Directed job sequence with $urandom weights/activations/results. A MAC
// model answers each K-beat window with a result taken from a queue; a
// scoreboard holds the expected (weight, activation) beats and results.
// ----------------------------------------------------------------------------
module tb_posit_mac_feeder;
   import posit_mac_pkg::*;

   localparam int W  = 8;
   localparam int KK = 9;
   localparam int NW = 16;

   typedef struct packed {
      logic [W-1:0] win;
      logic [W-1:0] din;
   } beat_t;

   logic clk_i = 1'b0;
   logic rstn  = 1'b0;
   always #5 clk_i = ~clk_i;

   posit_mac_feeder_if #(.WIDTH(W), .NWIN_W(NW)) bus ();

   posit_mac_feeder #(.WIDTH(W), .K(KK), .NWIN_W(NW)) dut (
      .clk_i (clk_i),
      .rstn  (rstn),
      .bus   (bus)
   );

   int n_vec     = 0;
   int n_miscomp = 0;
   int cyc       = 0;
   always @(posedge clk_i) cyc++;

   beat_t        exp_beat_q[$];
   logic [W-1:0] resp_q[$];
   logic [W-1:0] exp_res_q[$];
   logic [W-1:0] w_model[KK];
   logic [W-1:0] act_model[KK];

   int beats_seen     = 0;
   int results_seen   = 0;
   int done_seen      = 0;
   int busy_cnt       = 0;
   int first_beat_cyc = 0;
   int last_beat_cyc  = 0;
   int hs_cyc         = 0;
   int done_cyc       = 0;
   int stray_cnt      = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miscomp++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // MAC model + scoreboard, sampling mid-cycle after all drivers settle.
   initial begin
      int           win_beats = 0;
      int           cd        = 0;
      int           stray_done = 0;
      int           pending_win = 0;
      bit           prev_hold = 0;
      bit           prev_res_vld = 0;
      logic [W-1:0] prev_data = '0;
      logic [W-1:0] pend = '0;
      beat_t        eb;
      bus.mac_vld_i = 1'b0;
      bus.mac_acc_i = '0;
      forever begin
         @(negedge clk_i);
         #1;
         bus.mac_vld_i = 1'b0;
         if (!rstn) begin
            win_beats = 0; cd = 0; pending_win = 0;
            prev_hold = 0; prev_res_vld = 0;
            exp_beat_q.delete(); resp_q.delete(); exp_res_q.delete();
            continue;
         end
         if (stray_cnt != stray_done) begin
            stray_done++;
            bus.mac_vld_i = 1'b1;
            bus.mac_acc_i = 8'hEE;
         end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               bus.mac_vld_i = 1'b1;
               bus.mac_acc_i = pend;
            end
         end
         if (bus.res_vld_o && !prev_res_vld) pending_win--;
         prev_res_vld = bus.res_vld_o;
         if (bus.mac_vld_o) begin
            if (win_beats == 0) begin
               check("win_order", pending_win, 0);
               first_beat_cyc = cyc;
            end
            last_beat_cyc = cyc;
            if (exp_beat_q.size() == 0) check("beat_unexpected", exp_beat_q.size(), 1);
            else begin
               eb = exp_beat_q.pop_front();
               check("beat_win", bus.mac_win_o, eb.win);
               check("beat_din", bus.mac_din_o, eb.din);
            end
            beats_seen++;
            win_beats++;
            if (win_beats == KK) begin
               win_beats = 0;
               pending_win++;
               cd = 2;
               pend = (resp_q.size() != 0) ? resp_q.pop_front() : 8'h00;
            end
         end
         if (prev_hold) begin
            check("res_hold_vld", bus.res_vld_o, 1);
            check("res_hold_data", bus.res_data_o, prev_data);
         end
         if (bus.res_vld_o && bus.res_rdy_i) begin
            if (exp_res_q.size() == 0) check("res_unexpected", exp_res_q.size(), 1);
            else check("res_data", bus.res_data_o, exp_res_q.pop_front());
            results_seen++;
            hs_cyc = cyc;
         end
         prev_hold = bus.res_vld_o & ~bus.res_rdy_i;
         prev_data = bus.res_data_o;
         if (bus.done_o) begin
            done_seen++;
            done_cyc = cyc;
         end
         if (bus.busy_o) busy_cnt++;
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},     bus.busy_o,     0);
      check({tag, "_done"},     bus.done_o,     0);
      check({tag, "_err"},      bus.err_o,      0);
      check({tag, "_res_vld"},  bus.res_vld_o,  0);
      check({tag, "_res_data"}, bus.res_data_o, 0);
      check({tag, "_mac_vld"},  bus.mac_vld_o,  0);
      check({tag, "_mac_win"},  bus.mac_win_o,  0);
      check({tag, "_mac_din"},  bus.mac_din_o,  0);
      check({tag, "_d_rdy"},    bus.d_rdy_o,    0);
   endtask

   task automatic start_job(input logic [NW-1:0] n);
      @(negedge clk_i);
      bus.start_i    = 1'b1;
      bus.cfg_nwin_i = n;
      @(negedge clk_i);
      bus.start_i    = 1'b0;
      bus.cfg_nwin_i = NW'($urandom);
   endtask

   task automatic load_weights(input bit gaps);
      int i = 0;
      int guard = 0;
      while (i < KK && guard < 200) begin
         @(negedge clk_i);
         bus.w_vld_i  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.w_data_i = bus.w_vld_i ? w_model[i] : W'($urandom);
         if (bus.w_vld_i) i++;
         guard++;
      end
      if (i < KK) check("wload_timeout", i, KK);
      @(negedge clk_i);
      bus.w_vld_i = 1'b0;
   endtask

   // Offers activations first..last-1; an accept is d_vld_i & d_rdy_o.
   task automatic drive_acts(input int first, input int last, input bit toggle);
      int    i = first;
      int    guard = 0;
      bit    ph = 1'b1;
      beat_t eb;
      while (i < last && guard < 400) begin
         @(negedge clk_i);
         bus.d_vld_i  = toggle ? ph : 1'b1;
         ph           = ~ph;
         bus.d_data_i = bus.d_vld_i ? act_model[i] : W'($urandom);
         if (bus.d_vld_i && bus.d_rdy_o) begin
            eb.win = w_model[i];
            eb.din = act_model[i];
            exp_beat_q.push_back(eb);
            i++;
         end
         guard++;
      end
      if (i < last) check("act_timeout", i, last);
      @(negedge clk_i);
      bus.d_vld_i = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0 = done_seen;
      int g = 0;
      while (done_seen == d0 && g < budget) begin
         @(negedge clk_i);
         #2;
         g++;
      end
      check("job_done", done_seen != d0, 1);
   endtask

   task automatic push_result(input logic [W-1:0] v);
      resp_q.push_back(v);
      exp_res_q.push_back(v);
   endtask

   task automatic randomize_weights();
      for (int i = 0; i < KK; i++) w_model[i] = W'($urandom);
   endtask

   task automatic randomize_acts();
      for (int i = 0; i < KK; i++) act_model[i] = W'($urandom);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, r0, d0, bz0, g;
      bus.start_i = 0; bus.cfg_nwin_i = '0; bus.w_vld_i = 0; bus.w_data_i = '0;
      bus.d_vld_i = 0; bus.d_data_i = '0; bus.res_rdy_i = 1'b1;

      // Reset state
      rstn = 1'b0;
      repeat (3) @(negedge clk_i);
      check_idle_outputs("reset");
      rstn = 1'b1;

      // 1: single window, all 0x40, back-to-back
      b0 = beats_seen; r0 = results_seen; d0 = done_seen;
      for (int i = 0; i < KK; i++) begin w_model[i] = 8'h40; act_model[i] = 8'h40; end
      push_result(8'h5A);
      start_job(1);
      load_weights(0);
      drive_acts(0, KK, 0);
      wait_done(100);
      check("t1_beats",    beats_seen - b0, KK);
      check("t1_span",     last_beat_cyc - first_beat_cyc, KK - 1);
      check("t1_results",  results_seen - r0, 1);
      check("t1_done_lat", done_cyc - hs_cyc, 1);
      check("t1_done_cnt", done_seen - d0, 1);
      check("t1_busy",     bus.busy_o, 0);

      // 2: three windows, result consumer stalled after window 1
      b0 = beats_seen; r0 = results_seen; d0 = done_seen;
      randomize_weights();
      for (int n = 0; n < 3; n++) push_result(W'($urandom));
      bus.res_rdy_i = 1'b0;
      randomize_acts();
      start_job(3);
      load_weights(1);
      drive_acts(0, KK, 0);
      g = 0;
      while (!bus.res_vld_o && g < 50) begin @(negedge clk_i); #2; g++; end
      check("t2_res_wait", bus.res_vld_o, 1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         // start_i and w_vld_i must both be ignored mid-job.
         bus.start_i    = (c == 0);
         bus.cfg_nwin_i = NW'(5);
         bus.w_vld_i    = 1'b1;
         bus.w_data_i   = W'($urandom);
         bus.d_vld_i    = 1'b1;
         bus.d_data_i   = W'($urandom);
         check("t2_d_rdy_stall", bus.d_rdy_o, 0);
      end
      @(negedge clk_i);
      bus.start_i = 0; bus.w_vld_i = 0; bus.d_vld_i = 0;
      check("t2_beats_held", beats_seen - b0, KK);
      bus.res_rdy_i = 1'b1;
      randomize_acts();
      drive_acts(0, KK, 0);
      randomize_acts();
      drive_acts(0, KK, 0);
      wait_done(200);
      check("t2_beats",   beats_seen - b0, 3 * KK);
      check("t2_results", results_seen - r0, 3);
      check("t2_done",    done_seen - d0, 1);

      // 3: d_vld_i toggling, two windows
      b0 = beats_seen; r0 = results_seen;
      randomize_weights();
      push_result(W'($urandom));
      push_result(W'($urandom));
      start_job(2);
      load_weights(0);
      randomize_acts();
      drive_acts(0, KK, 1);
      randomize_acts();
      drive_acts(0, KK, 1);
      wait_done(200);
      check("t3_beats",   beats_seen - b0, 2 * KK);
      check("t3_results", results_seen - r0, 2);

      // 4: empty job
      b0 = beats_seen; d0 = done_seen; bz0 = busy_cnt;
      start_job(0);
      check("t4_done_pulse", bus.done_o, 1);
      check("t4_d_rdy",      bus.d_rdy_o, 0);
      @(negedge clk_i);
      check("t4_done_clear", bus.done_o, 0);
      repeat (4) @(negedge clk_i);
      #2;
      check("t4_busy_never", busy_cnt - bz0, 0);
      check("t4_no_beats",   beats_seen - b0, 0);
      check("t4_done_cnt",   done_seen - d0, 1);

      // 5: stray MAC pulse mid-window
      r0 = results_seen;
      randomize_weights();
      randomize_acts();
      push_result(W'($urandom));
      start_job(1);
      load_weights(0);
      drive_acts(0, 4, 0);
      stray_cnt++;
      repeat (3) @(negedge clk_i);
      check("t5_err_set", bus.err_o, 1);
      check("t5_buf_empty", bus.res_vld_o, 0);
      drive_acts(4, KK, 0);
      wait_done(100);
      check("t5_results", results_seen - r0, 1);
      check("t5_err_sticky", bus.err_o, 1);

      // 6: reset during beat 5, then a normal job
      randomize_weights();
      randomize_acts();
      push_result(W'($urandom));
      start_job(1);
      load_weights(0);
      drive_acts(0, 5, 0);
      d0 = done_seen;
      @(negedge clk_i);
      rstn = 1'b0;
      @(negedge clk_i);
      check_idle_outputs("t6_reset");
      rstn = 1'b1;
      repeat (4) @(negedge clk_i);
      #2;
      check("t6_no_done", done_seen - d0, 0);
      b0 = beats_seen; r0 = results_seen; d0 = done_seen;
      randomize_weights();
      push_result(W'($urandom));
      push_result(W'($urandom));
      start_job(2);
      load_weights(1);
      randomize_acts();
      drive_acts(0, KK, 1);
      randomize_acts();
      drive_acts(0, KK, 0);
      wait_done(200);
      check("t6_beats",   beats_seen - b0, 2 * KK);
      check("t6_results", results_seen - r0, 2);
      check("t6_done",    done_seen - d0, 1);

      repeat (2) @(negedge clk_i);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
      $finish;
   end

endmodule
